// File: rtl/biquad8_coeff_loader_if.sv
// Register-side and biquad-side signal bundle for the coefficient loader.
// The master drives the requests; the slave (loader) drives the chain outputs.
interface biquad8_coeff_loader_if #(
    parameter int NCOEFF = 12,
    parameter int CBITS  = 18
);
    localparam int AW = $clog2(NCOEFF);

    logic             wr_i;
    logic [AW-1:0]    waddr_i;
    logic [CBITS-1:0] wdat_i;
    logic             load_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic             bypass_o;
    logic [CBITS-1:0] coeff_dat_o;
    logic             coeff_wr_o;
    logic             coeff_update_o;

    modport master (
        output wr_i, waddr_i, wdat_i, load_i,
        input  busy_o, done_o, err_o, bypass_o,
        input  coeff_dat_o, coeff_wr_o, coeff_update_o
    );

    modport slave (
        input  wr_i, waddr_i, wdat_i, load_i,
        output busy_o, done_o, err_o, bypass_o,
        output coeff_dat_o, coeff_wr_o, coeff_update_o
    );
endinterface

// File: rtl/biquad8_coeff_loader.sv
// Shadow-buffered coefficient loader: bypass, serial B-cascade shift,
// single commit, settle, release.
module biquad8_coeff_loader #(
    parameter int NCOEFF      = 12,
    parameter int CBITS       = 18,
    parameter int BYPASS_WAIT = 16,
    parameter int SETTLE      = 16
) (
    input  logic clk,
    input  logic rst,
    biquad8_coeff_loader_if.slave bus
);
    localparam int AW   = $clog2(NCOEFF);
    localparam int M1   = (BYPASS_WAIT > NCOEFF) ? BYPASS_WAIT : NCOEFF;
    localparam int MAXV = (SETTLE > M1) ? SETTLE : M1;
    localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;

    localparam logic [AW-1:0] LAST_A = AW'(NCOEFF - 1);
    localparam logic [CW-1:0] BW_M1  = CW'(BYPASS_WAIT - 1);
    localparam logic [CW-1:0] N_M1   = CW'(NCOEFF - 1);
    localparam logic [CW-1:0] ST_M1  = CW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYPASS,
        S_SHIFT,
        S_UPDATE,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CBITS-1:0] dat_q, dat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             byp_q, byp_d;
    logic             cwr_q, cwr_d;
    logic             upd_q, upd_d;

    logic [CBITS-1:0] mem_q [NCOEFF];
    logic             idle;
    logic             mem_we;

    assign idle   = (state_q == S_IDLE);
    assign mem_we = idle && bus.wr_i && !rst && (bus.waddr_i <= LAST_A);

    // Shadow RAM has no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[bus.waddr_i] <= bus.wdat_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.load_i) begin
                    state_d = S_BYPASS;
                    cnt_d   = BW_M1;
                end
            end
            S_BYPASS: begin
                if (cnt_q == '0) begin
                    state_d = S_SHIFT;
                    cnt_d   = N_M1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SHIFT: begin
                // Counter doubles as read address: farthest DSP first.
                dat_d = mem_q[cnt_q[AW-1:0]];
                if (cnt_q == '0) begin
                    state_d = S_UPDATE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_UPDATE: begin
                state_d = S_SETTLE;
                cnt_d   = ST_M1;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (idle && bus.load_i) begin
            err_d = 1'b0;
        end else if (!idle && (bus.wr_i || bus.load_i)) begin
            err_d = 1'b1;
        end

        // Outputs decode the next state so they are registered and aligned.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        byp_d  = (state_d == S_BYPASS) || (state_d == S_SHIFT) ||
                 (state_d == S_UPDATE) || (state_d == S_SETTLE);
        cwr_d  = (state_d == S_SHIFT);
        upd_d  = (state_d == S_UPDATE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            byp_q   <= 1'b0;
            cwr_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            byp_q   <= byp_d;
            cwr_q   <= cwr_d;
            upd_q   <= upd_d;
        end
    end

    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.err_o          = err_q;
    assign bus.bypass_o       = byp_q;
    assign bus.coeff_dat_o    = dat_q;
    assign bus.coeff_wr_o     = cwr_q;
    assign bus.coeff_update_o = upd_q;
endmodule

// File: doc/biquad8_coeff_loader.md
# biquad8_coeff_loader

Sequencer that loads a new coefficient set into the incremental biquad DSP chain without glitching live data. The register side writes coefficient words into a shadow buffer and then issues a load command. The loader forces the IIR into bypass, shifts the words serially down the DSP B-cascade (`coeff_wr`), and commits them with a single `coeff_update`. It then waits out the pipeline before releasing bypass. It sits between the register interface and the `coeff_dat/coeff_wr/coeff_update/bypass` inputs of one biquad8 IIR section.

## Interface
- `NCOEFF`, 12: number of words in the B-cascade chain (2*(NSAMP-2) for NSAMP=8).
- `CBITS`, 18: coefficient width (DSP B port).
- `BYPASS_WAIT`, 16: cycles `bypass_o` is held before the first `coeff_wr_o`. Covers the consumer bypass pipeline plus the per-sample ripple.
- `SETTLE`, 16: cycles after `coeff_update_o` before `bypass_o` is released.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `wr_i` in 1: shadow buffer write strobe.
- `waddr_i` in $clog2(NCOEFF): shadow write address. Address 0 is nearest the chain input.
- `wdat_i` in CBITS: shadow write data.
- `load_i` in 1: start-load pulse.
- `busy_o` out 1: high from load acceptance until `done_o`.
- `done_o` out 1: one-cycle pulse when the sequence completes.
- `err_o` out 1: sticky flag for a write or load that was dropped because the block was busy.
- `bypass_o` out 1: to the biquad `bypass_i`.
- `coeff_dat_o` out CBITS: to the biquad `coeff_dat_i`.
- `coeff_wr_o` out 1: to the biquad `coeff_wr_i`.
- `coeff_update_o` out 1: to the biquad `coeff_update_i`.

## Operation
- Shadow buffer: NCOEFF×CBITS distributed RAM.
  - It is not cleared by reset.
  - `wr_i` in IDLE writes `wdat_i` to `waddr_i`.
  - A write with `waddr_i >= NCOEFF` is ignored and does not set `err_o`.
- FSM states: IDLE, BYPASS, SHIFT, UPDATE, SETTLE, DONE.
- IDLE:
  - `load_i`=1 → BYPASS.
  - A same-cycle `wr_i` is committed first and is included in the load.
  - Accepting a load clears `err_o`.
- BYPASS: `bypass_o`=1. Counter runs BYPASS_WAIT cycles, then → SHIFT.
- SHIFT:
  - `coeff_wr_o`=1 for exactly NCOEFF cycles.
  - Words are read in descending address order, NCOEFF-1 down to 0, so the farthest DSP is written first.
  - `coeff_dat_o` carries word k one cycle after the `coeff_wr_o` cycle for k. The biquad registers its B clock enables internally, so data lags the strobe by 1.
  - → UPDATE.
- UPDATE: one cycle. `coeff_update_o`=1, and `coeff_dat_o` holds word 0 in this cycle. → SETTLE.
- SETTLE: `bypass_o` stays 1 for SETTLE cycles, then → DONE.
- DONE: `done_o`=1 and `bypass_o`=0 in this cycle; `busy_o` is still 1. → IDLE.
- In any non-IDLE state:
  - `wr_i` is dropped and sets `err_o`.
  - `load_i` is ignored and sets `err_o`.
- Outside SHIFT/UPDATE, `coeff_dat_o` holds its last value. Toggling it would only waste power.
- All outputs are registered.
- Reset mid-sequence:
  - All outputs return to reset values next cycle and the FSM goes to IDLE.
  - If UPDATE has not occurred, the B2 registers are untouched, so the old coefficients remain active. Only B1 holds partial data, which the next full load overwrites.

## Timing
- Reset values: `busy_o`, `done_o`, `err_o`, `bypass_o`, `coeff_wr_o`, `coeff_update_o` = 0; `coeff_dat_o` = 0.
- Load accepted at cycle t:
  - `busy_o`=`bypass_o`=1 at t+1.
  - First `coeff_wr_o` at t+1+BYPASS_WAIT.
  - Last `coeff_wr_o` at t+BYPASS_WAIT+NCOEFF.
  - `coeff_update_o` at t+1+BYPASS_WAIT+NCOEFF.
  - `bypass_o` falls and `done_o` pulses at t+2+BYPASS_WAIT+NCOEFF+SETTLE.
  - `busy_o` falls at t+3+BYPASS_WAIT+NCOEFF+SETTLE.
- With defaults, `done_o` occurs 46 cycles after load.
- A new `load_i` is accepted in the first cycle `busy_o`=0.

## Test plan
- Write words 0x00100+k, k=0..11, then load → exactly 12 `coeff_wr_o` cycles. `coeff_dat_o` sequence is 0x0010B down to 0x00100, each one cycle after its strobe. `coeff_update_o` pulses once, coincident with 0x00100. `done_o` arrives 46 cycles after load.
- Check `bypass_o` → high 1 cycle after load. First `coeff_wr_o` is 16 cycles later. `bypass_o` low 17 cycles after `coeff_update_o`. `bypass_o` never low while `coeff_wr_o` or `coeff_update_o` is high.
- Assert `wr_i`(addr 3, 0x3FFFF) and `load_i` in the same IDLE cycle → 0x3FFFF appears as the 9th shifted word. `err_o`=0.
- Issue `wr_i` and `load_i` mid-SHIFT → both dropped and `err_o`=1. Shift order and content are unchanged. `err_o` clears on the next accepted load.
- Assert `rst` at the 5th `coeff_wr_o` → all outputs 0 next cycle, with no `coeff_update_o` or `done_o`. A subsequent load completes the full 12-word sequence normally.
- Write to `waddr_i`=12 and 15 → shadow contents are unchanged, verified by a subsequent load, and `err_o`=0.
